// File: rtl/key_entry_ctrl_if.sv
// Interface between the keypad scanner / downstream unit and key_entry_ctrl.
// Optional macro KEY_ECHO_EN adds the ASCII echo lines for the UART transmitter.
interface key_entry_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  IN_key;
  logic [3:0]            IN_value;
  logic                  IN_ack;
  logic [4*DIGITS-1:0]   OUT_a;
  logic [4*DIGITS-1:0]   OUT_b;
  logic                  OUT_op;
  logic                  OUT_req;
  logic                  OUT_evt;
  logic [3:0]            OUT_code;
  logic [1:0]            OUT_state;
`ifdef KEY_ECHO_EN
  logic [7:0]            OUT_echo;
  logic                  OUT_echo_vld;
`endif

  // Scanner/downstream side: drives key inputs and ack, observes results.
  modport master (
    output IN_key, IN_value, IN_ack,
    input  OUT_a, OUT_b, OUT_op, OUT_req, OUT_evt, OUT_code, OUT_state
`ifdef KEY_ECHO_EN
    , input OUT_echo, OUT_echo_vld
`endif
  );

  // Controller side.
  modport slave (
    input  IN_key, IN_value, IN_ack,
    output OUT_a, OUT_b, OUT_op, OUT_req, OUT_evt, OUT_code, OUT_state
`ifdef KEY_ECHO_EN
    , output OUT_echo, OUT_echo_vld
`endif
  );
endinterface

// File: rtl/key_entry_ctrl.sv
// Keypad entry sequencer: debounces scanner key levels into single press
// events, assembles two BCD operands plus an operator, and hands the finished
// expression downstream with a req/ack handshake.
// Optional macro KEY_ECHO_EN adds an ASCII echo of each press.
module key_entry_ctrl #(
  parameter int DIGITS     = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic          IN_clk,
  input  logic          IN_rst_n,
  key_entry_ctrl_if.slave bus
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam int SW = $clog2(STABLE_CYC + 1);

  localparam logic [3:0] CODE_ADD = 4'd10;
  localparam logic [3:0] CODE_SUB = 4'd11;
  localparam logic [3:0] CODE_CLR = 4'd14;
  localparam logic [3:0] CODE_EQ  = 4'd15;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    REQ     = 2'd2
  } state_t;

  logic [3:0]    cand;
  logic [SW-1:0] stable_cnt;
  logic          armed;
  logic          evt_q;
  logic [3:0]    code_q;

  state_t        state;
  logic [W-1:0]  a_q, b_q;
  logic [CW-1:0] cnt_a, cnt_b;
  logic          op_q, req_q;

  logic accept;
  logic is_digit;
  logic clear_all;

  // A press is accepted on the edge where a stable code reaches STABLE_CYC.
  assign accept   = bus.IN_key && (bus.IN_value == cand) && armed &&
                    (stable_cnt == SW'(STABLE_CYC - 1));
  assign is_digit = (cand <= 4'd9);

  // Clearing has one source of truth: 'C' outside REQ, or ack inside REQ.
  // Ack beats a same-edge key because keys are ignored in REQ anyway.
  assign clear_all = (state == REQ) ? bus.IN_ack
                                    : (accept && cand == CODE_CLR);

  // Debounce: track candidate code, count stable cycles, one event per hold.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge IN_clk or negedge IN_rst_n) begin
    if (!IN_rst_n) begin
      cand       <= 4'd0;
      stable_cnt <= '0;
      armed      <= 1'b1;
      evt_q      <= 1'b0;
      code_q     <= 4'd0;
    end else begin
      evt_q <= accept;
      if (accept) begin
        armed  <= 1'b0;
        code_q <= cand;
      end
      if (!bus.IN_key) begin
        stable_cnt <= '0;
        armed      <= 1'b1;
      end else if (bus.IN_value != cand) begin
        cand       <= bus.IN_value;
        stable_cnt <= SW'(1);
      end else if (stable_cnt != SW'(STABLE_CYC)) begin
        stable_cnt <= stable_cnt + SW'(1);
      end
    end
  end

  // Operand/operator FSM acting on accepted presses; encoding 3 recovers to ENTER_A.
  always_ff @(posedge IN_clk or negedge IN_rst_n) begin
    if (!IN_rst_n) begin
      state <= ENTER_A;
      a_q   <= '0;
      b_q   <= '0;
      cnt_a <= '0;
      cnt_b <= '0;
      op_q  <= 1'b0;
      req_q <= 1'b0;
    end else if (clear_all) begin
      state <= ENTER_A;
      a_q   <= '0;
      b_q   <= '0;
      cnt_a <= '0;
      cnt_b <= '0;
      op_q  <= 1'b0;
      req_q <= 1'b0;
    end else begin
      case (state)
        ENTER_B: begin
          if (accept) begin
            if (is_digit) begin
              if (cnt_b < CW'(DIGITS)) begin
                b_q   <= {b_q[W-5:0], cand};
                cnt_b <= cnt_b + CW'(1);
              end
            end else if (cand == CODE_ADD || cand == CODE_SUB) begin
              if (cnt_b == '0) op_q <= (cand == CODE_SUB);
            end else if (cand == CODE_EQ) begin
              if (cnt_b != '0) begin
                req_q <= 1'b1;
                state <= REQ;
              end
            end
          end
        end
        REQ: begin
          // Operands frozen until ack (handled by clear_all).
        end
        default: begin
          state <= ENTER_A;
          if (accept) begin
            if (is_digit) begin
              if (cnt_a < CW'(DIGITS)) begin
                a_q   <= {a_q[W-5:0], cand};
                cnt_a <= cnt_a + CW'(1);
              end
            end else if (cand == CODE_ADD || cand == CODE_SUB) begin
              if (cnt_a != '0) begin
                op_q  <= (cand == CODE_SUB);
                state <= ENTER_B;
              end
            end
          end
        end
      endcase
    end
  end

  assign bus.OUT_a     = a_q;
  assign bus.OUT_b     = b_q;
  assign bus.OUT_op    = op_q;
  assign bus.OUT_req   = req_q;
  assign bus.OUT_evt   = evt_q;
  assign bus.OUT_code  = code_q;
  assign bus.OUT_state = (state == REQ || state == ENTER_B) ? state : ENTER_A;

`ifdef KEY_ECHO_EN
  logic [7:0] echo_q;
  logic       echo_vld_q;
  logic [7:0] echo_char;

  // Map the candidate code to its ASCII character.
  // NOTE: always_comb outputs get a default first so no path infers a latch.
  always_comb begin
    echo_char = 8'h00;
    case (cand)
      CODE_ADD: echo_char = 8'h2B;
      CODE_SUB: echo_char = 8'h2D;
      CODE_CLR: echo_char = 8'h43;
      CODE_EQ:  echo_char = 8'h3D;
      default:  if (is_digit) echo_char = 8'h30 + {4'd0, cand};
    endcase
  end

  // Echo every accepted press except the unused codes 12/13.
  always_ff @(posedge IN_clk or negedge IN_rst_n) begin
    if (!IN_rst_n) begin
      echo_q     <= 8'h00;
      echo_vld_q <= 1'b0;
    end else begin
      echo_vld_q <= accept && (cand != 4'd12) && (cand != 4'd13);
      if (accept && cand != 4'd12 && cand != 4'd13) echo_q <= echo_char;
    end
  end

  assign bus.OUT_echo     = echo_q;
  assign bus.OUT_echo_vld = echo_vld_q;
`endif
endmodule
